corescore_stream_arbiter: RTL and testbench

- Packet-granular round-robin arbiter sharing one byte-wide AXI-Stream sink (the UART emitter) between NUM_SRC source streams (one per core in corescorecore).
- Locks grant to one source from its first accepted beat until the beat carrying tlast, so messages never interleave.
- Registered output slice: one-cycle data latency, full throughput within a packet.

---
 rtl/corescore_stream_arbiter.sv | 112 +++++++++++
 tb/tb_corescore_stream_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/corescore_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one byte-wide AXI-Stream sink between NUM_SRC
// sources, with a registered output slice. A source keeps the grant until its tlast beat.
module corescore_stream_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SRC_W   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [8*NUM_SRC-1:0] i_tdata,
  input  logic [NUM_SRC-1:0]   i_tlast,
  input  logic [NUM_SRC-1:0]   i_tvalid,
  output logic [NUM_SRC-1:0]   o_tready,
  output logic [7:0]           o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 i_tready,
  output logic [NUM_SRC-1:0]   o_grant,
  output logic                 o_busy
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e             state_q;
  logic [SRC_W-1:0]   last_q;
  logic [SRC_W-1:0]   grant_idx_q;
  logic [SRC_W-1:0]   pick_idx;
  logic [NUM_SRC-1:0] pick_oh;
  logic               pick_found;
  int unsigned        cand;
  logic               out_free;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic               accept;

  // The slice can take a new beat when empty or when its current beat drains this cycle.
  assign out_free = !o_tvalid || i_tready;
  assign o_tready = (state_q == StLocked && out_free) ? o_grant : '0;
  assign accept   = (state_q == StLocked) && sel_valid && out_free;

  // Circular search for the first valid source after the last one served.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = (32'(last_q) + 32'd1 + i) % NUM_SRC;
      if (!pick_found && i_tvalid[SRC_W'(cand)]) begin
        pick_found              = 1'b1;
        pick_idx                = SRC_W'(cand);
        pick_oh[SRC_W'(cand)]   = 1'b1;
      end
    end
  end

  // One-hot grant makes the source mux a plain AND-OR.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (o_grant[k]) begin
        sel_data  = sel_data | i_tdata[8*k +: 8];
        sel_valid = sel_valid | i_tvalid[k];
        sel_last  = sel_last | i_tlast[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      last_q      <= SRC_W'(NUM_SRC - 1);
      grant_idx_q <= '0;
      o_grant     <= '0;
      o_busy      <= 1'b0;
      o_tvalid    <= 1'b0;
      o_tdata     <= '0;
      o_tlast     <= 1'b0;
    end else begin
      if (accept) begin
        o_tvalid <= 1'b1;
        o_tdata  <= sel_data;
        o_tlast  <= sel_last;
      end else if (i_tready) begin
        o_tvalid <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (pick_found) begin
            state_q     <= StLocked;
            grant_idx_q <= pick_idx;
            o_grant     <= pick_oh;
            o_busy      <= 1'b1;
          end
        end
        StLocked: begin
          if (accept && sel_last) begin
            state_q <= StIdle;
            o_grant <= '0;
            o_busy  <= 1'b0;
            last_q  <= grant_idx_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Self-checking bench: directed cycle vectors plus round-robin traffic against a scoreboard.
module tb_corescore_stream_arbiter;

  localparam int NS = 4;

  logic          i_clk;
  logic          i_rst;
  logic [31:0]   i_tdata;
  logic [NS-1:0] i_tlast;
  logic [NS-1:0] i_tvalid;
  logic [NS-1:0] o_tready;
  logic [7:0]    o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic          i_tready;
  logic [NS-1:0] o_grant;
  logic          o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  corescore_stream_arbiter #(.NUM_SRC(NS), .SRC_W(2)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .o_tready (o_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .i_tready (i_tready),
    .o_grant  (o_grant),
    .o_busy   (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    logic        rst;
    logic [3:0]  tv;
    logic [3:0]  tl;
    logic [31:0] td;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic [3:0]  er;
    logic [3:0]  eg;
    logic        eb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(logic rst, logic [3:0] tv, logic [3:0] tl, logic [31:0] td,
                             logic rdy, logic ev, logic [7:0] ed, logic el, logic [3:0] er,
                             logic [3:0] eg, logic eb);
    vec_t r;
    r.rst = rst; r.tv = tv; r.tl = tl; r.td = td; r.rdy = rdy;
    r.ev = ev; r.ed = ed; r.el = el; r.er = er; r.eg = eg; r.eb = eb;
    return r;
  endfunction

  function automatic vec_t vrst();
    return v(1'b1, 4'b0, 4'b0, 32'h0, 1'b1, 1'b0, 8'h0, 1'b0, 4'b0, 4'b0, 1'b0);
  endfunction

  function automatic int pkt_len(int s, int p, bit fixed3);
    return fixed3 ? 3 : 1 + ((p * 3 + s * 5 + p / 7) % 4);
  endfunction

  function automatic logic [7:0] pkt_byte(int s, int p, int b, bit fixed3);
    logic [3:0] hi;
    logic [3:0] lo;
    int         x;
    hi = 4'(s);
    lo = 4'(b);
    x  = s * 61 + p * 7 + b * 13 + 1;
    return fixed3 ? {hi, lo} : x[7:0];
  endfunction

  task automatic do_reset();
    i_rst    = 1'b1;
    i_tvalid = '0;
    i_tlast  = '0;
    i_tdata  = '0;
    i_tready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  // All sources stay valid until their npkt packets are sent, so the sink order is strict
  // round robin: packet p of src0, src1, src2, src3, then packet p+1 ...
  task automatic run_traffic(input int npkt, input bit rand_ready, input bit fixed3);
    logic [8:0] exp_q[$];
    int         pkt_idx[NS];
    int         beat_idx[NS];
    bit         adv[NS];
    bit         is_last[NS];
    int         exp_src;
    int         last_end;
    int         cycle;
    for (int p = 0; p < npkt; p++) begin
      for (int s = 0; s < NS; s++) begin
        int len;
        len = pkt_len(s, p, fixed3);
        for (int b = 0; b < len; b++) exp_q.push_back({b == len - 1, pkt_byte(s, p, b, fixed3)});
      end
    end
    for (int s = 0; s < NS; s++) begin
      pkt_idx[s]  = 0;
      beat_idx[s] = 0;
    end
    exp_src  = 0;
    last_end = -1;
    cycle    = 0;
    while (exp_q.size() != 0 && cycle < 20000) begin
      for (int s = 0; s < NS; s++) begin
        if (pkt_idx[s] < npkt) begin
          i_tvalid[s]       = 1'b1;
          i_tdata[8*s +: 8] = pkt_byte(s, pkt_idx[s], beat_idx[s], fixed3);
          i_tlast[s]        = (beat_idx[s] == pkt_len(s, pkt_idx[s], fixed3) - 1);
        end else begin
          i_tvalid[s]       = 1'b0;
          i_tdata[8*s +: 8] = 8'h00;
          i_tlast[s]        = 1'b0;
        end
      end
      i_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("tready outside grant", 32'(o_tready & ~o_grant), 32'h0);
      for (int s = 0; s < NS; s++) begin
        adv[s]     = i_tvalid[s] && o_tready[s];
        is_last[s] = i_tlast[s];
        if (adv[s] && beat_idx[s] == 0) begin
          check("packet source", 32'(s), 32'(exp_src));
          if (!rand_ready && last_end >= 0) check("inter-packet gap", 32'(cycle - last_end), 32'd2);
        end
        if (adv[s] && is_last[s]) begin
          exp_src  = (s + 1) % NS;
          last_end = cycle;
        end
      end
      if (o_tvalid && i_tready) check("sink beat", {23'h0, o_tlast, o_tdata}, {23'h0, exp_q.pop_front()});
      @(posedge i_clk);
      for (int s = 0; s < NS; s++) begin
        if (adv[s]) begin
          if (is_last[s]) begin
            beat_idx[s] = 0;
            pkt_idx[s]++;
          end else begin
            beat_idx[s]++;
          end
        end
      end
      cycle++;
      #1;
    end
    check("traffic drained", 32'(exp_q.size()), 32'h0);
    i_tvalid = '0;
    i_tlast  = '0;
    i_tdata  = '0;
    #1;
    check("sink idle after traffic", 32'(o_tvalid), 32'h0);
    check("busy clear after traffic", 32'(o_busy), 32'h0);
  endtask

  initial begin
    i_rst    = 1'b1;
    i_tvalid = '0;
    i_tlast  = '0;
    i_tdata  = '0;
    i_tready = 1'b1;

    // Single source: src1 sends 48 69 0A.
    vecs.push_back(vrst());
    vecs.push_back(v(0, 4'b0010, 4'b0000, 32'h0000_4800, 1, 0, 8'h00, 0, 4'b0010, 4'b0010, 1));
    vecs.push_back(v(0, 4'b0010, 4'b0000, 32'h0000_4800, 1, 1, 8'h48, 0, 4'b0010, 4'b0010, 1));
    vecs.push_back(v(0, 4'b0010, 4'b0000, 32'h0000_6900, 1, 1, 8'h69, 0, 4'b0010, 4'b0010, 1));
    vecs.push_back(v(0, 4'b0010, 4'b0010, 32'h0000_0A00, 1, 1, 8'h0A, 1, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 0, 4'b0000, 4'b0000, 0));
    // Single-beat packets from src0 and src3.
    vecs.push_back(vrst());
    vecs.push_back(v(0, 4'b1001, 4'b1001, 32'hD300_00A0, 1, 0, 8'h00, 0, 4'b0001, 4'b0001, 1));
    vecs.push_back(v(0, 4'b1001, 4'b1001, 32'hD300_00A0, 1, 1, 8'hA0, 1, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b1000, 4'b1000, 32'hD300_0000, 1, 0, 8'h00, 0, 4'b1000, 4'b1000, 1));
    vecs.push_back(v(0, 4'b1000, 4'b1000, 32'hD300_0000, 1, 1, 8'hD3, 1, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 0, 4'b0000, 4'b0000, 0));
    // Backpressure: sink stalls five cycles mid-packet on src2.
    vecs.push_back(vrst());
    vecs.push_back(v(0, 4'b0100, 4'b0000, 32'h0020_0000, 1, 0, 8'h00, 0, 4'b0100, 4'b0100, 1));
    vecs.push_back(v(0, 4'b0100, 4'b0000, 32'h0020_0000, 1, 1, 8'h20, 0, 4'b0100, 4'b0100, 1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(0, 4'b0100, 4'b0000, 32'h0021_0000, 0, 1, 8'h20, 0, 4'b0000, 4'b0100, 1));
    vecs.push_back(v(0, 4'b0100, 4'b0000, 32'h0021_0000, 1, 1, 8'h21, 0, 4'b0100, 4'b0100, 1));
    vecs.push_back(v(0, 4'b0100, 4'b0000, 32'h0022_0000, 1, 1, 8'h22, 0, 4'b0100, 4'b0100, 1));
    vecs.push_back(v(0, 4'b0100, 4'b0100, 32'h0023_0000, 1, 1, 8'h23, 1, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 0, 4'b0000, 4'b0000, 0));
    // Source gap: src2 drops valid mid-packet while src0 waits.
    vecs.push_back(vrst());
    vecs.push_back(v(0, 4'b0100, 4'b0000, 32'h0020_0000, 1, 0, 8'h00, 0, 4'b0100, 4'b0100, 1));
    vecs.push_back(v(0, 4'b0100, 4'b0000, 32'h0020_0000, 1, 1, 8'h20, 0, 4'b0100, 4'b0100, 1));
    vecs.push_back(v(0, 4'b0101, 4'b0000, 32'h0021_0055, 1, 1, 8'h21, 0, 4'b0100, 4'b0100, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 4'b0001, 4'b0000, 32'h0000_0055, 1, 0, 8'h00, 0, 4'b0100, 4'b0100, 1));
    vecs.push_back(v(0, 4'b0101, 4'b0100, 32'h0022_0055, 1, 1, 8'h22, 1, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0001, 4'b0000, 32'h0000_0055, 1, 0, 8'h00, 0, 4'b0001, 4'b0001, 1));
    // Reset mid-packet on src1, then pointer restarts at src0.
    vecs.push_back(vrst());
    vecs.push_back(v(0, 4'b0010, 4'b0000, 32'h0000_1000, 1, 0, 8'h00, 0, 4'b0010, 4'b0010, 1));
    vecs.push_back(v(0, 4'b0010, 4'b0000, 32'h0000_1000, 1, 1, 8'h10, 0, 4'b0010, 4'b0010, 1));
    vecs.push_back(v(1, 4'b0010, 4'b0000, 32'h0000_1100, 1, 0, 8'h00, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0011, 4'b0001, 32'h0000_1277, 1, 0, 8'h00, 0, 4'b0001, 4'b0001, 1));
    vecs.push_back(v(0, 4'b0011, 4'b0001, 32'h0000_1277, 1, 1, 8'h77, 1, 4'b0000, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0010, 4'b0000, 32'h0000_1200, 1, 0, 8'h00, 0, 4'b0010, 4'b0010, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      i_rst    = vecs[i].rst;
      i_tvalid = vecs[i].tv;
      i_tlast  = vecs[i].tl;
      i_tdata  = vecs[i].td;
      i_tready = vecs[i].rdy;
      @(posedge i_clk);
      #1;
      check($sformatf("v%0d tvalid", i), 32'(o_tvalid), 32'(vecs[i].ev));
      check($sformatf("v%0d tready", i), 32'(o_tready), 32'(vecs[i].er));
      check($sformatf("v%0d grant", i), 32'(o_grant), 32'(vecs[i].eg));
      check($sformatf("v%0d busy", i), 32'(o_busy), 32'(vecs[i].eb));
      if (vecs[i].ev) begin
        check($sformatf("v%0d tdata", i), 32'(o_tdata), 32'(vecs[i].ed));
        check($sformatf("v%0d tlast", i), 32'(o_tlast), 32'(vecs[i].el));
      end
    end

    // Contention: 3-beat packets from every source, sink always ready.
    do_reset();
    run_traffic(2, 1'b0, 1'b1);
    // Random sink readiness over 1000 packets of varied length.
    do_reset();
    run_traffic(250, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
